writeback_stage_ext: RTL and testbench
======================================

Name: writeback_stage_ext

Overview:
Parametrised writeback stage for the pipelined core. It registers the M-to-W pipeline boundary with stall and flush control and per-slot valid tracking. It selects among NUM_SRC result sources, sign- or zero-extends sub-word loads, and produces the register-file write port and the forwarding result. It also maintains a retired-instruction counter for the CSR block.

Parameters:
XLEN, 32, datapath width in bits (32 or 64)
NUM_SRC, 4, number of result sources (0 = ALU result, 1 = load data, 2 = PC+4, 3 = immediate/CSR)
LOAD_SRC, 1, source index that receives load extraction
CNT_W, 64, retired-instruction counter width
SEL_W, $clog2(NUM_SRC), derived result-select width

Ports:
i_Clk  in  1  clock, rising edge
i_Reset  in  1  asynchronous reset, active-low
i_StallW  in  1  hold the W register
i_FlushW  in  1  load a bubble into the W register
i_ValidM  in  1  M slot holds a real instruction
i_RegWriteM  in  1  instruction writes rd
i_ResultSrcM  in  SEL_W  result source select
i_LoadTypeM  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD when XLEN=64)
i_SrcM  in  NUM_SRC x XLEN  packed source operands; i_SrcM[0] is the ALU result and load address
i_RdM  in  5  destination register
o_ValidW  out  1  W slot valid
o_RdW  out  5  destination register, to the hazard unit and register file
o_RegWriteW  out  1  register-file write enable
o_ResultW  out  XLEN  write-back data, also forwarded
o_InstRetW  out  CNT_W  retired-instruction count

Behaviour:
- Reset (i_Reset=0, asynchronous):
  - Registered state: valid, regwrite, rd, sel, loadtype and all captured sources clear to 0.
  - Counter clears to 0.
  - Outputs: o_ValidW=0, o_RegWriteW=0, o_RdW=0, o_ResultW=0, o_InstRetW=0.
  - Deassertion takes effect on the next rising edge.
- W register update, priority on each rising edge: flush > stall > load.
  - Flush: valid=0 and regwrite=0. Data fields are don't-care; clear them to 0.
  - Stall (no flush): all fields hold.
  - Otherwise: all M inputs are captured.
  - Latency is 1 cycle from M inputs to W outputs.
- o_RegWriteW = validW & regwriteW & (rdW != 0). This combinational gate guarantees x0 is never written.
- If a valid instruction is held by a stall, o_RegWriteW stays asserted every stalled cycle. Rewriting the same value is permitted.
- Result mux (combinational on W fields):
  - o_ResultW = captured source[selW].
  - The LOAD_SRC slot is replaced by the extracted load value.
  - selW >= NUM_SRC gives 0.
- Load extraction, using off = captured i_SrcM[0][2:0] (XLEN=64) or [1:0] (XLEN=32):
  - LB/LBU: byte at off*8. Sign-extend for LB, zero-extend for LBU.
  - LH/LHU: halfword at (off with bit0 cleared)*8. Sign-extend for LH, zero-extend for LHU.
  - LW: word at (off with bits[1:0] cleared)*8. Sign-extends to XLEN when XLEN=64; pass-through when XLEN=32.
  - LD (XLEN=64 only): full word pass-through.
  - Unlisted funct3: full XLEN pass-through.
- Retire counter: increments by 1 on each edge where the W register captures (no stall, no flush) and i_ValidM=1.
  - o_InstRetW therefore already counts the instruction currently in W.
  - Wraps modulo 2^CNT_W.
  - Holds during stall and flush.
- Reset mid-stall discards the held instruction. The counter is lost, not saved.
- o_ValidW=0 forces o_RegWriteW=0 whatever the stale data fields contain.

Decomposition:
- Shared package wb_pkg holds:
  - result-source enum (RES_ALU=0, RES_LOAD=1, RES_PC4=2, RES_IMM=3)
  - load funct3 constants
  - default XLEN and CNT_W localparams
- One sub-module, load_extract: purely combinational, XLEN-parametrised (data, offset, funct3 → extended value). It is reused later by the AMO unit.
- The pipeline register, counter and result mux stay in the top level.

Test Plan:
- Reset/basic: hold i_Reset=0 and drive ALU source 0x1234 with rd=5. Release reset and present the instruction with sel=0, valid=1, regwrite=1 → one cycle later o_ResultW=0x00001234, o_RdW=5, o_RegWriteW=1, o_InstRetW=1.
- Load extraction: source1=0x80FF7F01, addr[1:0]=1.
  - LB → 0x0000007F.
  - addr=3, LB → 0xFFFFFF80.
  - LHU addr=2 → 0x000080FF.
  - LH addr=2 → 0xFFFF80FF.
  - LW → 0x80FF7F01.
- x0 guard and sources: rd=0 with regwrite=1 → o_RegWriteW=0 and the counter still increments. sel=2 with PC+4=0x104 → o_ResultW=0x104.
- Stall/flush:
  - Stall for 3 cycles → W outputs and counter frozen, o_RegWriteW stays 1.
  - Stall and flush together → o_ValidW=0, o_RegWriteW=0, counter unchanged.
- Wrap and async reset:
  - CNT_W=4: after 16 valid captures o_InstRetW=0.
  - Assert i_Reset between clock edges → all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage and its load-extraction helper.
package wb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 64;

  // Result-source encoding used by the decoder and the W-stage mux.
  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2,
    RES_IMM  = 2'd3
  } res_src_e;

  // Load funct3 encodings.
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LD  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  // Byte-offset width within one XLEN word.
  function automatic int off_width(input int xlen);
    return (xlen == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/writeback_stage_ext_load_extract.sv
// Combinational sub-word load extraction: picks the addressed byte, halfword
// or word out of an XLEN-wide data word and sign- or zero-extends it.
module load_extract
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int OFF_W = off_width(XLEN)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  result
);

  logic [OFF_W-1:0] half_off;
  logic [OFF_W-1:0] word_off;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;

  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] zext8(input logic [7:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // Halfword and word accesses ignore the low offset bits (naturally aligned).
  assign half_off = off & ~OFF_W'(1);
  assign word_off = off & ~OFF_W'(3);

  assign byte_v = 8'(data >> {off, 3'b000});
  assign half_v = 16'(data >> {half_off, 3'b000});
  assign word_v = 32'(data >> {word_off, 3'b000});

  // Select and extend by funct3; LD and unlisted encodings pass the word through.
  always_comb begin
    result = data;
    case (funct3)
      LT_LB:   result = sext8(byte_v);
      LT_LBU:  result = zext8(byte_v);
      LT_LH:   result = sext16(half_v);
      LT_LHU:  result = zext16(half_v);
      LT_LW:   result = sext32(word_v);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage_ext.sv
// Writeback stage: M-to-W pipeline register with stall/flush, result-source
// selection with load extraction, x0-guarded register-file write enable and
// a retired-instruction counter for the CSR block.
module writeback_stage_ext
  import wb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_SRC  = 4,
  parameter int LOAD_SRC = int'(RES_LOAD),
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SEL_W    = $clog2(NUM_SRC)
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic                          i_StallW,
  input  logic                          i_FlushW,
  input  logic                          i_ValidM,
  input  logic                          i_RegWriteM,
  input  logic [SEL_W-1:0]              i_ResultSrcM,
  input  logic [2:0]                    i_LoadTypeM,
  input  logic [NUM_SRC-1:0][XLEN-1:0]  i_SrcM,
  input  logic [4:0]                    i_RdM,
  output logic                          o_ValidW,
  output logic [4:0]                    o_RdW,
  output logic                          o_RegWriteW,
  output logic [XLEN-1:0]               o_ResultW,
  output logic [CNT_W-1:0]              o_InstRetW
);

  localparam int OFF_W = off_width(XLEN);

  logic                         vld_p1;
  logic                         regwrite_p1;
  logic [4:0]                   rd_p1;
  logic [SEL_W-1:0]             sel_p1;
  logic [2:0]                   ltype_p1;
  logic [NUM_SRC-1:0][XLEN-1:0] src_p1;
  logic [CNT_W-1:0]             instret_p1;
  logic [XLEN-1:0]              load_val;
  logic [XLEN-1:0]              result;
  logic                         capture;

  // A new M instruction enters W only when neither flushed nor stalled.
  assign capture = !i_FlushW && !i_StallW;

  // ---- M -> W boundary: flush beats stall beats load ----
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      rd_p1       <= '0;
      sel_p1      <= '0;
      ltype_p1    <= '0;
      src_p1      <= '0;
    end else if (i_FlushW) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      rd_p1       <= '0;
      sel_p1      <= '0;
      ltype_p1    <= '0;
      src_p1      <= '0;
    end else if (!i_StallW) begin
      vld_p1      <= i_ValidM;
      regwrite_p1 <= i_RegWriteM;
      rd_p1       <= i_RdM;
      sel_p1      <= i_ResultSrcM;
      ltype_p1    <= i_LoadTypeM;
      src_p1      <= i_SrcM;
    end
  end

  // Count every valid instruction as it enters W, so the count includes W itself.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      instret_p1 <= '0;
    end else if (capture && i_ValidM) begin
      instret_p1 <= instret_p1 + CNT_W'(1);
    end
  end

  load_extract #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_extract (
    .data   (src_p1[LOAD_SRC]),
    .off    (src_p1[0][OFF_W-1:0]),
    .funct3 (ltype_p1),
    .result (load_val)
  );

  // Result mux; select codes beyond NUM_SRC fall through to zero.
  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_p1 == SEL_W'(i)) begin
        result = (i == LOAD_SRC) ? load_val : src_p1[i];
      end
    end
  end

  assign o_ValidW    = vld_p1;
  assign o_RdW       = rd_p1;
  assign o_RegWriteW = vld_p1 & regwrite_p1 & (rd_p1 != 5'd0);
  assign o_ResultW   = result;
  assign o_InstRetW  = instret_p1;

endmodule

// File: tb/tb_writeback_stage_ext.sv
// Testbench for writeback_stage_ext (XLEN=32, NUM_SRC=4, CNT_W=4).
module tb_writeback_stage_ext;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 4;
  localparam int CNT_W   = 4;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         stall = 1'b0;
  logic                         flush = 1'b0;
  logic                         vld_m = 1'b0;
  logic                         rw_m = 1'b0;
  logic [1:0]                   sel_m = '0;
  logic [2:0]                   lt_m = '0;
  logic [NUM_SRC-1:0][XLEN-1:0] src_m = '0;
  logic [4:0]                   rd_m = '0;

  logic                         o_valid;
  logic [4:0]                   o_rd;
  logic                         o_rw;
  logic [XLEN-1:0]              o_res;
  logic [CNT_W-1:0]             o_cnt;

  writeback_stage_ext #(
    .XLEN     (XLEN),
    .NUM_SRC  (NUM_SRC),
    .LOAD_SRC (1),
    .CNT_W    (CNT_W)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst_n),
    .i_StallW     (stall),
    .i_FlushW     (flush),
    .i_ValidM     (vld_m),
    .i_RegWriteM  (rw_m),
    .i_ResultSrcM (sel_m),
    .i_LoadTypeM  (lt_m),
    .i_SrcM       (src_m),
    .i_RdM        (rd_m),
    .o_ValidW     (o_valid),
    .o_RdW        (o_rd),
    .o_RegWriteW  (o_rw),
    .o_ResultW    (o_res),
    .o_InstRetW   (o_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  // Reference state: what W architecturally holds after each edge.
  bit          m_valid = 0;
  bit          m_rw = 0;
  int unsigned m_rd = 0;
  int unsigned m_res = 0;
  int unsigned m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic w, input logic [4:0] r,
                         input logic [31:0] res, input logic [3:0] cnt);
    check({name, "_valid"}, 64'(o_valid), 64'(v));
    check({name, "_rw"},    64'(o_rw),    64'(w));
    check({name, "_rd"},    64'(o_rd),    64'(r));
    check({name, "_res"},   64'(o_res),   64'(res));
    check({name, "_cnt"},   64'(o_cnt),   64'(cnt));
  endtask

  // Load semantics from the ISA: pick byte/halfword by address, extend by type.
  function automatic int unsigned model_load(input int unsigned d, input int unsigned off,
                                             input int unsigned f3);
    int unsigned b;
    int unsigned h;
    b = (d >> (8 * off)) & 255;
    h = (d >> (16 * (off / 2))) & 65535;
    case (f3)
      0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4:       return b;
      1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5:       return h;
      default: return d;
    endcase
  endfunction

  task automatic drive(input bit v, input bit w, input int unsigned s, input int unsigned l,
                       input int unsigned s0, input int unsigned s1, input int unsigned s2,
                       input int unsigned s3, input int unsigned r, input bit st, input bit fl);
    exp_t e;
    vld_m    = v;
    rw_m     = w;
    sel_m    = 2'(s);
    lt_m     = 3'(l);
    src_m[0] = s0;
    src_m[1] = s1;
    src_m[2] = s2;
    src_m[3] = s3;
    rd_m     = 5'(r);
    stall    = st;
    flush    = fl;
    if (fl) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_res = 0;
    end else if (!st) begin
      m_valid = v;
      m_rw    = w;
      m_rd    = r & 31;
      case (s & 3)
        0:       m_res = s0;
        1:       m_res = model_load(s1, s0 & 3, l & 7);
        2:       m_res = s2;
        default: m_res = s3;
      endcase
      if (v) m_cnt = (m_cnt + 1) % 16;
    end
    e.valid = m_valid;
    e.rw    = m_valid && m_rw && (m_rd != 0);
    e.rd    = 5'(m_rd);
    e.res   = m_res;
    e.cnt   = 4'(m_cnt);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  // Monitor: compare the W outputs once per cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("sb_valid", 64'(o_valid), 64'(mon_e.valid));
      check("sb_rw",    64'(o_rw),    64'(mon_e.rw));
      check("sb_rd",    64'(o_rd),    64'(mon_e.rd));
      check("sb_res",   64'(o_res),   64'(mon_e.res));
      check("sb_cnt",   64'(o_cnt),   64'(mon_e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a live instruction at the inputs.
    vld_m = 1; rw_m = 1; sel_m = 0; src_m[0] = 32'h1234; rd_m = 5;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    rst_n = 1;

    drive(1, 1, 0, 0, 32'h1234, 0, 0, 0, 5, 0, 0);
    chk_out("basic", 1, 1, 5, 32'h0000_1234, 1);

    drive(1, 1, 1, 0, 1, 32'h80FF_7F01, 0, 0, 7, 0, 0);
    check("lb_off1", 64'(o_res), 64'h0000_007F);
    drive(1, 1, 1, 0, 3, 32'h80FF_7F01, 0, 0, 7, 0, 0);
    check("lb_off3", 64'(o_res), 64'hFFFF_FF80);
    drive(1, 1, 1, 5, 2, 32'h80FF_7F01, 0, 0, 7, 0, 0);
    check("lhu_off2", 64'(o_res), 64'h0000_80FF);
    drive(1, 1, 1, 1, 2, 32'h80FF_7F01, 0, 0, 7, 0, 0);
    check("lh_off2", 64'(o_res), 64'hFFFF_80FF);
    drive(1, 1, 1, 2, 0, 32'h80FF_7F01, 0, 0, 7, 0, 0);
    check("lw", 64'(o_res), 64'h80FF_7F01);

    drive(1, 1, 0, 0, 32'hAAAA, 0, 0, 0, 0, 0, 0);
    check("x0_rw", 64'(o_rw), 64'd0);
    check("x0_cnt", 64'(o_cnt), 64'd7);

    drive(1, 1, 2, 0, 32'h50, 0, 32'h104, 0, 9, 0, 0);
    check("pc4", 64'(o_res), 64'h104);
    drive(1, 1, 3, 0, 0, 0, 0, 32'hDEAD_BEEF, 3, 0, 0);
    chk_out("imm", 1, 1, 3, 32'hDEAD_BEEF, 9);

    // Stall with changing M inputs: W must hold and keep writing.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, 12, 1, 0);
      chk_out("stall", 1, 1, 3, 32'hDEAD_BEEF, 9);
    end

    // Asynchronous reset between edges while an instruction is held.
    #6;
    rst_n = 0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    m_valid = 0; m_rw = 0; m_rd = 0; m_res = 0; m_cnt = 0;
    #1;
    rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
            $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 31), 0, 0);
    end
    check("wrap", 64'(o_cnt), 64'd0);

    drive(1, 1, 0, 0, 32'h77, 0, 0, 0, 4, 0, 0);
    drive(1, 1, 0, 0, 32'h88, 0, 0, 0, 6, 1, 1);
    chk_out("stall_flush", 0, 0, 0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 31), $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
    end

    #10;
    check("sb_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
